// File: rtl/core_pkg.sv
// Shared definitions for the core datapath: opcode constants, stall FSM states and
// a helper that sizes the stall counter.
package core_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } stall_state_t;

  // Counter must hold the largest latency or timeout value; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Stall-cycle counter: load-to-1 at the start of an access, saturating increment,
// and a greater-or-equal compare against a limit.
module stall_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [Width-1:0] i_limit,
  output logic [Width-1:0] o_count,
  output logic             o_ge
);

  logic [Width-1:0] r_count;

  // Count register; load wins over increment, increment saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= Width'(1);
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + Width'(1);
    end
  end

  assign o_count = r_count;
  assign o_ge    = (r_count >= i_limit);

endmodule

// File: rtl/mem_stall_ctrl.sv
// Memory-stall controller: decodes the opcode, holds the PC and register-file write
// for a minimum latency on loads/stores, optionally waits for mem_ready, and raises
// a sticky error when a stall exceeds TIMEOUT cycles.
module mem_stall_ctrl
  import core_pkg::*;
#(
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned STORE_LAT = 0,
  parameter int unsigned USE_READY = 0,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_enable,
  output logic       reg_write_gate,
  output logic       mem_busy,
  output logic       err
);

  localparam int unsigned CntW = cnt_width(LOAD_LAT, STORE_LAT, TIMEOUT);

  stall_state_t    r_state;
  logic [CntW-1:0] r_lat;
  logic            r_timeout;
  logic            r_err;

  logic [CntW-1:0] w_lat_dec;
  logic [CntW-1:0] w_k;
  logic [CntW-1:0] w_limit;
  logic            w_ge;
  logic            w_ready_ok;
  logic            w_timeout_hit;
  logic            w_cnt_load;
  logic            w_cnt_inc;

  // Opcode class to effective latency.
  always_comb begin
    w_lat_dec = '0;
    if (opcode == OP_LOAD) begin
      w_lat_dec = CntW'(LOAD_LAT);
    end else if (opcode == OP_STORE) begin
      w_lat_dec = CntW'(STORE_LAT);
    end
  end

  assign w_ready_ok    = (USE_READY != 0) ? mem_ready : 1'b1;
  assign w_limit       = r_lat - CntW'(1);
  assign w_timeout_hit = (TIMEOUT != 0) && ((32'(w_k) + 32'd1) == TIMEOUT);

  // Counter control: restart on a new stalling access, advance while still waiting.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_inc  = 1'b0;
    unique case (r_state)
      IDLE:    w_cnt_load = (w_lat_dec != '0);
      WAIT:    w_cnt_inc  = !(w_ge && w_ready_ok) && !w_timeout_hit;
      default: ;
    endcase
  end

  stall_counter #(
    .Width(CntW)
  ) u_stall_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_inc  (w_cnt_inc),
    .i_limit(w_limit),
    .o_count(w_k),
    .o_ge   (w_ge)
  );

  // Stall FSM with latched latency, timeout marker for DONE, and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat     <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_lat_dec != '0) begin
            r_lat <= w_lat_dec;
            if ((w_lat_dec == CntW'(1)) && w_ready_ok) r_state <= DONE;
            else                                       r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_ge && w_ready_ok) begin
            r_state <= DONE;
          end else if (w_timeout_hit) begin
            r_state   <= DONE;
            r_timeout <= 1'b1;
            r_err     <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational; held low throughout reset.
  always_comb begin
    pc_enable      = 1'b0;
    reg_write_gate = 1'b0;
    mem_busy       = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (w_lat_dec == '0) begin
            pc_enable      = 1'b1;
            reg_write_gate = 1'b1;
          end else begin
            mem_busy = 1'b1;
          end
        end
        WAIT: mem_busy = 1'b1;
        DONE: begin
          pc_enable      = 1'b1;
          reg_write_gate = !r_timeout;
        end
        default: ;
      endcase
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: five configurations share one stimulus stream; a
// cycle-index model predicts every output each cycle, and directed sequences pin
// literal waveforms from hand-worked examples.
module tb_mem_stall_ctrl;

  localparam int N = 5;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ADD = 7'b0110011;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   opcode;
  logic         mem_ready;
  logic [N-1:0] pc, rwg, busy, err;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 0;

  always #5 clk = ~clk;

  // d0: defaults; d1: LOAD_LAT 3; d2: LOAD_LAT 2 with ready;
  // d3: LOAD 2 / STORE 1 with ready and TIMEOUT 5; d4: LOAD_LAT 4.
  mem_stall_ctrl u_d0 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_enable(pc[0]), .reg_write_gate(rwg[0]), .mem_busy(busy[0]), .err(err[0])
  );
  mem_stall_ctrl #(.LOAD_LAT(3), .STORE_LAT(0), .USE_READY(0), .TIMEOUT(0)) u_d1 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_enable(pc[1]), .reg_write_gate(rwg[1]), .mem_busy(busy[1]), .err(err[1])
  );
  mem_stall_ctrl #(.LOAD_LAT(2), .STORE_LAT(0), .USE_READY(1), .TIMEOUT(0)) u_d2 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_enable(pc[2]), .reg_write_gate(rwg[2]), .mem_busy(busy[2]), .err(err[2])
  );
  mem_stall_ctrl #(.LOAD_LAT(2), .STORE_LAT(1), .USE_READY(1), .TIMEOUT(5)) u_d3 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_enable(pc[3]), .reg_write_gate(rwg[3]), .mem_busy(busy[3]), .err(err[3])
  );
  mem_stall_ctrl #(.LOAD_LAT(4), .STORE_LAT(0), .USE_READY(0), .TIMEOUT(0)) u_d4 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_enable(pc[4]), .reg_write_gate(rwg[4]), .mem_busy(busy[4]), .err(err[4])
  );

  function automatic int cfg_lat(input int i, input logic [6:0] op);
    int l, s;
    case (i)
      0: begin l = 1; s = 0; end
      1: begin l = 3; s = 0; end
      2: begin l = 2; s = 0; end
      3: begin l = 2; s = 1; end
      default: begin l = 4; s = 0; end
    endcase
    if (op == LD) return l;
    if (op == ST) return s;
    return 0;
  endfunction

  function automatic bit cfg_ready(input int i);
    return (i == 2) || (i == 3);
  endfunction

  function automatic int cfg_timeout(input int i);
    return (i == 3) ? 5 : 0;
  endfunction

  // Model: per instance, whether an access is in flight, the 0-based cycle index
  // within it, its latency, and whether the completion cycle has been reached.
  bit m_act [N];
  bit m_done[N];
  bit m_to  [N];
  bit m_err [N];
  int m_c   [N];
  int m_lat [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit act, done, to, e, rok;
      int c, lat;
      act = m_act[i]; done = m_done[i]; to = m_to[i]; e = m_err[i];
      c = m_c[i]; lat = m_lat[i];
      rok = cfg_ready(i) ? mem_ready : 1'b1;
      if (rst) begin
        act = 0; done = 0; to = 0; e = 0;
      end else if (act && done) begin
        act = 0; done = 0;
      end else begin
        bit stalling;
        stalling = act;
        if (!act) begin
          lat = cfg_lat(i, opcode);
          c = 0;
          stalling = (lat > 0);
        end
        if (stalling) begin
          act = 1;
          // Cycle c+1 is the completion cycle once the minimum latency is covered
          // and memory is ready, or when the stall reaches the timeout.
          if ((c + 1 >= lat) && rok) begin
            done = 1; to = 0;
          end else if ((cfg_timeout(i) > 0) && (c + 1 == cfg_timeout(i))) begin
            done = 1; to = 1; e = 1;
          end else begin
            c = c + 1;
          end
        end
      end
      m_act[i] <= act; m_done[i] <= done; m_to[i] <= to; m_err[i] <= e;
      m_c[i] <= c; m_lat[i] <= lat;
    end
  end

  // Expected {pc_enable, reg_write_gate, mem_busy, err} for instance i this cycle.
  function automatic logic [3:0] model_out(input int i);
    if (rst) return 4'b0000;
    if (!m_act[i]) begin
      if (cfg_lat(i, opcode) == 0) return {3'b110, m_err[i]};
      return {3'b001, m_err[i]};
    end
    if (m_done[i]) return {1'b1, !m_to[i], 1'b0, m_err[i]};
    return {3'b001, m_err[i]};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_d%0d", i), {pc[i], rwg[i], busy[i], err[i]}, model_out(i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset across one clock edge and checks outputs are all low meanwhile.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_pc",   {3'b0, pc[0]},   4'b0);
    check("rst_all",  {pc[4], rwg[1], busy[1], err[3]}, 4'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] e_pc, e_rwg, e_busy, r_pat;
    rst = 1'b1;
    opcode = ADD;
    mem_ready = 1'b0;
    tick();
    chk_en = 1;

    // ADD on defaults: single-cycle behaviour.
    do_reset();
    opcode = ADD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("add_d0_c%0d", c), {pc[0], rwg[0], busy[0], err[0]}, 4'b1100);
      tick();
    end

    // LOAD_LAT 3: pc 0,0,0,1.
    do_reset();
    opcode = LD; mem_ready = 1'b1;
    e_pc = 8'b0000_1000; e_busy = 8'b0000_0111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("ld3_d1_c%0d", c), {pc[1], rwg[1], busy[1], 1'b0},
            {e_pc[c], e_pc[c], e_busy[c], 1'b0});
      tick();
    end
    opcode = ADD;

    // Ready-gated LOAD_LAT 2: ready pulse in cycle 0 ignored, first real ready in 4.
    do_reset();
    opcode = LD;
    r_pat = 8'b0001_0001; e_pc = 8'b0010_0000;
    for (int c = 0; c < 6; c++) begin
      mem_ready = r_pat[c];
      @(negedge clk);
      check($sformatf("rdy_d2_c%0d", c), {3'b0, pc[2]}, {3'b0, e_pc[c]});
      tick();
    end
    opcode = ADD; mem_ready = 1'b0;

    // Timeout 5 with ready stuck low: DONE in cycle 5 without write, err sticks.
    do_reset();
    opcode = LD; mem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 5) check($sformatf("to_d3_c%0d", c), {pc[3], rwg[3], busy[3], err[3]}, 4'b0010);
      else       check("to_d3_done", {pc[3], rwg[3], busy[3], err[3]}, 4'b1001);
      tick();
    end
    opcode = ADD;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("to_d3_after_c%0d", c), {pc[3], rwg[3], busy[3], err[3]}, 4'b1101);
      tick();
    end

    // load, store, load on LOAD_LAT 2 / STORE_LAT 0 (ready held high).
    do_reset();
    mem_ready = 1'b1;
    e_pc = 8'b0100_1100;
    for (int c = 0; c < 7; c++) begin
      opcode = (c == 3) ? ST : LD;
      @(negedge clk);
      check($sformatf("lsl_d2_c%0d", c), {3'b0, pc[2]}, {3'b0, e_pc[c]});
      tick();
    end
    opcode = ADD;

    // Reset in cycle 2 of a LOAD_LAT 4 access: access restarts with 4 fresh stalls.
    do_reset();
    opcode = LD; mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst4_pre_c%0d", c), {pc[4], rwg[4], busy[4], err[4]}, 4'b0010);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst4_mid", {pc[4], rwg[4], busy[4], err[4]}, 4'b0000);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rst4_post_c%0d", c), {pc[4], rwg[4], busy[4], err[4]},
            (c == 4) ? 4'b1100 : 4'b0010);
      tick();
    end

    // Randomized traffic checked by the model; periodic ready-low stretches force timeouts.
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)      opcode = LD;
      else if (r < 6) opcode = ST;
      else if (r < 9) opcode = ADD;
      else            opcode = 7'($urandom);
      mem_ready = ((k % 200) < 12) ? 1'b0 : 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
